sev_seg_scan: RTL

- Time-multiplexed driver for N_DIGITS common-anode seven-segment digits that share one set of cathode lines.
- Latches a packed nibble word into a shadow register and scans one digit per refresh slot.
- Inserts anode dead time between slots to suppress ghosting.
- Adds the following over the single-digit decoder: optional hex glyphs, per-digit blank, per-digit decimal point, leading-zero blanking and a frame strobe.
- Sits between datapath/lab top-levels and the board's CA..CG/DP/AN pins.

---
 rtl/sev_seg_pkg.sv | 30 +++
 rtl/sev_seg_decode.sv | 12 +
 rtl/sev_seg_scan.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment width,
// active-low glyph table and the nibble-to-glyph decode function.
package sev_seg_pkg;

  localparam int SEG_W = 7;

  // All cathodes high: every segment dark.
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  // Glyphs ordered {CA,CB,CC,CD,CE,CF,CG}, active-low.
  localparam logic [SEG_W-1:0] GLYPH [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Decimal-only mode shows nothing for 10..15 rather than a hex letter.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble,
                                                  input logic       hex_mode);
    logic [SEG_W-1:0] seg;
    if (!hex_mode && (nibble > 4'd9)) begin
      seg = SEG_OFF;
    end else begin
      seg = GLYPH[nibble];
    end
    return seg;
  endfunction

endpackage

// File: rtl/sev_seg_decode.sv
// Single-digit nibble decoder; purely combinational wrapper of seg_decode.
module sev_seg_decode
  import sev_seg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  input  logic             hex_mode_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = seg_decode(nibble_i, hex_mode_i);

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with anode dead time,
// per-digit blank and decimal point, leading-zero blanking and frame strobe.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16,
  parameter int HEX_MODE    = 1,
  parameter int LZ_BLANK    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*N_DIGITS-1:0] DATA,
  input  logic [N_DIGITS-1:0]   DP,
  input  logic [N_DIGITS-1:0]   BLANK,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DPO,
  output logic [N_DIGITS-1:0]   AN,
  output logic                  FRAME
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;

  // Shadow copies of the display request
  logic [4*N_DIGITS-1:0] data_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic [N_DIGITS-1:0]   blank_q;

  // Registered pin drivers
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                dpo_q, dpo_d;
  logic                frame_q, frame_d;

  // Current-digit decode
  logic [3:0]          cur_nib;
  logic [SEG_W-1:0]    glyph;
  logic [N_DIGITS-1:0] upper_zero;
  logic                dark;

  assign cur_nib = data_q[{idx_q, 2'b00} +: 4];

  sev_seg_decode u_dec (
    .nibble_i   (cur_nib),
    .hex_mode_i (HEX_MODE != 0),
    .seg_o      (glyph)
  );

  // upper_zero[i]: nibble i and every more significant nibble are zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run           = run & (data_q[4*i +: 4] == 4'd0);
      upper_zero[i] = run;
    end
  end

  // Digit 0 is exempt from leading-zero blanking so a zero value still shows "0".
  assign dark = blank_q[idx_q] |
                ((LZ_BLANK != 0) && (idx_q != '0) && upper_zero[idx_q]);

  // Slot counter and digit index advance; disabled scanning parks at digit 0.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (!EN) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pin values derived from the current scan state, so anodes and cathodes move together.
  always_comb begin
    an_d    = '1;
    seg_d   = SEG_OFF;
    dpo_d   = 1'b1;
    frame_d = 1'b0;
    if (EN) begin
      frame_d = wrap_q;
      if (cnt_q >= CNT_DEAD) begin
        an_d[idx_q] = 1'b0;
        if (!dark) begin
          seg_d = glyph;
          dpo_d = ~dp_q[idx_q];
        end
      end
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dpo_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      if (LOAD) begin
        data_q  <= DATA;
        dp_q    <= DP;
        blank_q <= BLANK;
      end
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      frame_q <= frame_d;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DPO   = dpo_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule
